// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and run/drain controller for the 16-bit pipelined core.
// Latency: forwarding selects and stall/flush controls are combinational; state and stall counter update on clk.
// Backpressure: dm_busy_i freezes the pipeline (all stalls high) and the drain countdown.
module pipe_hazard_ctrl #(
   parameter int REG_WIDTH  = 4,
   parameter int NUM_SRC    = 2,
   parameter int FWD_STAGES = 2,
   parameter int PIPE_DEPTH = 5,
   parameter int ZERO_REG   = 1,
   parameter int CNT_WIDTH  = 16,
   localparam int SELW      = $clog2(FWD_STAGES + 1)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             stop_i,
   input  logic [NUM_SRC*REG_WIDTH-1:0]     rs_id,
   input  logic [NUM_SRC-1:0]               rs_id_vld,
   input  logic [NUM_SRC*REG_WIDTH-1:0]     rs_ex,
   input  logic                             mem_read_ex,
   input  logic [REG_WIDTH-1:0]             dst_ex,
   input  logic [FWD_STAGES-1:0]            wr_en_fwd,
   input  logic [FWD_STAGES*REG_WIDTH-1:0]  wr_reg_fwd,
   input  logic                             pc_src_i,
   input  logic                             jump_i,
   input  logic                             dm_busy_i,
   input  logic                             cnt_clr_i,
   output logic [NUM_SRC*SELW-1:0]          fwd_sel_o,
   output logic                             pc_stall,
   output logic                             stall_if_id,
   output logic                             stall_id_ex,
   output logic                             stall_ex_mem,
   output logic                             stall_mem_wb,
   output logic                             flush_if_id,
   output logic                             flush_id_ex,
   output logic                             flush_ex_mem,
   output logic                             run_o,
   output logic                             halted_o,
   output logic [CNT_WIDTH-1:0]             stall_cnt_o
);

   // Drain counter only ever holds 0..PIPE_DEPTH-1.
   localparam int DCW = (PIPE_DEPTH > 2) ? $clog2(PIPE_DEPTH) : 1;
   localparam logic [DCW-1:0] DRAIN_LEN = DCW'(PIPE_DEPTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [DCW-1:0]         drain_cnt_q, drain_cnt_d;
   logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
   logic                   lu;
   logic                   active;

   // Forwarding select: youngest matching writer wins, register 0 never forwards.
   always_comb begin
      fwd_sel_o = '0;
      for (int j = 0; j < NUM_SRC; j++) begin
         // Walk oldest to youngest so the lowest matching stage index is the last assignment.
         for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (wr_en_fwd[k] &&
                (wr_reg_fwd[k*REG_WIDTH +: REG_WIDTH] == rs_ex[j*REG_WIDTH +: REG_WIDTH]) &&
                !((ZERO_REG != 0) && (rs_ex[j*REG_WIDTH +: REG_WIDTH] == '0))) begin
               fwd_sel_o[j*SELW +: SELW] = SELW'(k + 1);
            end
         end
      end
   end

   // Load-use detection: a used ID source matches the destination of a load sitting in EX.
   always_comb begin
      lu = 1'b0;
      if (mem_read_ex && !((ZERO_REG != 0) && (dst_ex == '0))) begin
         for (int j = 0; j < NUM_SRC; j++) begin
            if (rs_id_vld[j] && (rs_id[j*REG_WIDTH +: REG_WIDTH] == dst_ex)) begin
               lu = 1'b1;
            end
         end
      end
   end

   assign active = (state_q == S_RUN) || (state_q == S_DRAIN);

   // Pipeline stall/flush controls: frozen when not running, RUN priority otherwise, drain overlay on top.
   always_comb begin
      pc_stall     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_ex  = 1'b1;
      stall_ex_mem = 1'b1;
      stall_mem_wb = 1'b1;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
      if (active) begin
         pc_stall     = 1'b0;
         stall_if_id  = 1'b0;
         stall_id_ex  = 1'b0;
         stall_ex_mem = 1'b0;
         stall_mem_wb = 1'b0;
         if (dm_busy_i) begin
            pc_stall     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            stall_mem_wb = 1'b1;
         end else if (pc_src_i) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
         end else if (lu) begin
            pc_stall     = 1'b1;
            stall_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
         end else if (jump_i) begin
            flush_if_id  = 1'b1;
         end
         // While draining, no new instruction may enter the pipe.
         if (state_q == S_DRAIN) begin
            pc_stall    = 1'b1;
            flush_if_id = 1'b1;
         end
      end
   end

   // Next-state, drain countdown and saturating stall counter.
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      stall_cnt_d = stall_cnt_q;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            // A halt alongside a taken branch is on the wrong path and is discarded.
            if (stop_i && !pc_src_i && !dm_busy_i) begin
               state_d     = S_DRAIN;
               drain_cnt_d = DRAIN_LEN;
            end
         end
         S_DRAIN: begin
            // A memory wait freezes the drain, including a branch that resolves during it;
            // the branch is acted on once the memory is ready and the pipe moves again.
            if (!dm_busy_i) begin
               if (pc_src_i) begin
                  state_d     = S_RUN;
                  drain_cnt_d = '0;
               end else begin
                  drain_cnt_d = drain_cnt_q - DCW'(1);
                  if (drain_cnt_q == DCW'(1)) begin
                     state_d = S_HALT;
                  end
               end
            end
         end
         default: begin
            state_d     = S_IDLE;
            drain_cnt_d = '0;
         end
      endcase

      if ((state_q == S_RUN) && (dm_busy_i || lu) && !pc_src_i && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end
      if (cnt_clr_i) begin
         stall_cnt_d = '0;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         drain_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign run_o       = active;
   assign halted_o    = (state_q == S_HALT);
   assign stall_cnt_o = stall_cnt_q;

endmodule
